// File: rtl/router_pkg.sv
// Shared definitions for the mesh router: port numbering and switch-allocator state encoding.
package router_pkg;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int SOUTH = 2;
    localparam int EAST  = 3;
    localparam int WEST  = 4;

    typedef enum logic {
        ALLOC_IDLE,
        ALLOC_LOCKED
    } alloc_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request found scanning upward from ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ   = 5,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 any
);

    // Scan ptr, ptr+1, ... wrapping modulo NUM_REQ and stop at the first requester
    always_comb begin
        int cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/router_switch_allocator.sv
// Zero-latency wormhole switch allocator with per-output packet locks, round-robin sharing and credit flow control.
module router_switch_allocator
    import router_pkg::*;
#(
    parameter int NUM_INPUTS        = 5,
    parameter int NUM_OUTPUTS       = 5,
    parameter int FLIT_BUFFER_DEPTH = 2,
    parameter int IN_WIDTH          = $clog2(NUM_INPUTS),
    parameter int PORT_WIDTH        = $clog2(NUM_OUTPUTS),
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_INPUTS-1:0]                    req_valid,
    input  logic [NUM_INPUTS-1:0][PORT_WIDTH-1:0]    req_port,
    input  logic [NUM_INPUTS-1:0]                    req_is_tail,
    input  logic [NUM_INPUTS-1:0][NUM_OUTPUTS-1:0]   disable_turns,
    input  logic [NUM_OUTPUTS-1:0]                   credit_in,
    output logic [NUM_INPUTS-1:0]                    grant,
    output logic [NUM_OUTPUTS-1:0][IN_WIDTH-1:0]     xbar_sel,
    output logic [NUM_OUTPUTS-1:0]                   out_send,
    output logic [NUM_OUTPUTS-1:0][CREDIT_WIDTH-1:0] credit_count,
    output logic                                     credit_overflow
);

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] grant_mat;
    logic [NUM_OUTPUTS-1:0]                 ovf_vec;

    for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
        logic [NUM_INPUTS-1:0]   eligible;
        logic [NUM_INPUTS-1:0]   arb_gnt;
        logic [IN_WIDTH-1:0]     arb_idx;
        logic                    arb_any;
        logic [NUM_INPUTS-1:0]   win_onehot;
        logic [IN_WIDTH-1:0]     winner;
        logic [IN_WIDTH-1:0]     next_ptr;
        logic                    win_valid;
        logic                    win_tail;
        logic                    send;
        logic                    ovf;
        logic [CREDIT_WIDTH-1:0] credits_next;
        alloc_state_e            state;
        logic [IN_WIDTH-1:0]     owner;
        logic [IN_WIDTH-1:0]     rr_ptr;
        logic [CREDIT_WIDTH-1:0] credits;
        logic [IN_WIDTH-1:0]     sel_q;

        // An input competes for this output only if it routes here and the turn is permitted
        always_comb begin
            eligible = '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                eligible[i] = req_valid[i] && (req_port[i] == PORT_WIDTH'(o)) && !disable_turns[i][o];
            end
        end

        rr_arbiter #(
            .NUM_REQ   (NUM_INPUTS),
            .IDX_WIDTH (IN_WIDTH)
        ) u_arb (
            .req (eligible),
            .ptr (rr_ptr),
            .gnt (arb_gnt),
            .idx (arb_idx),
            .any (arb_any)
        );

        // Pick the winner (lock owner overrides arbitration) and gate the send on credit and reset
        always_comb begin
            if (state == ALLOC_LOCKED) begin
                winner     = owner;
                win_valid  = eligible[owner];
                win_onehot = NUM_INPUTS'(1) << owner;
            end else begin
                winner     = arb_idx;
                win_valid  = arb_any;
                win_onehot = arb_gnt;
            end
            send     = rst_n && win_valid && (credits != '0);
            win_tail = req_is_tail[winner];
            next_ptr = (winner == IN_WIDTH'(NUM_INPUTS - 1)) ? '0 : winner + IN_WIDTH'(1);
        end

        // Credit bookkeeping; a return into a full counter saturates and reports overflow
        always_comb begin
            credits_next = credits;
            ovf          = 1'b0;
            if (send && !credit_in[o]) begin
                credits_next = credits - CREDIT_WIDTH'(1);
            end else if (!send && credit_in[o]) begin
                if (credits == CREDIT_MAX) begin
                    ovf = 1'b1;
                end else begin
                    credits_next = credits + CREDIT_WIDTH'(1);
                end
            end
        end

        // Lock FSM, round-robin pointer, credit counter and held crossbar select for this output
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= ALLOC_IDLE;
                owner   <= '0;
                rr_ptr  <= '0;
                credits <= CREDIT_MAX;
                sel_q   <= '0;
            end else begin
                credits <= credits_next;
                if (send) begin
                    sel_q <= winner;
                    unique case (state)
                        ALLOC_IDLE: begin
                            if (win_tail) begin
                                rr_ptr <= next_ptr;
                            end else begin
                                state <= ALLOC_LOCKED;
                                owner <= winner;
                            end
                        end
                        ALLOC_LOCKED: begin
                            if (win_tail) begin
                                state  <= ALLOC_IDLE;
                                rr_ptr <= next_ptr;
                            end
                        end
                        default: state <= ALLOC_IDLE;
                    endcase
                end
            end
        end

        assign out_send[o]     = send;
        assign xbar_sel[o]     = send ? winner : sel_q;
        assign grant_mat[o]    = send ? win_onehot : '0;
        assign credit_count[o] = credits;
        assign ovf_vec[o]      = ovf;
    end

    // Each input routes to a single port, so OR-ing the per-output grants never merges two winners
    always_comb begin
        grant = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            grant = grant | grant_mat[o];
        end
    end

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_overflow <= 1'b0;
        end else if (|ovf_vec) begin
            credit_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_router_switch_allocator.sv
// Directed scoreboard bench for the router switch allocator.
module tb_router_switch_allocator;
    import router_pkg::*;

    localparam int NI = 5;
    localparam int NO = 5;
    localparam int IW = 3;
    localparam int PW = 3;
    localparam int CW = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NI-1:0]         req_valid;
    logic [NI-1:0][PW-1:0] req_port;
    logic [NI-1:0]         req_is_tail;
    logic [NI-1:0][NO-1:0] disable_turns;
    logic [NO-1:0]         credit_in;
    logic [NI-1:0]         grant;
    logic [NO-1:0][IW-1:0] xbar_sel;
    logic [NO-1:0]         out_send;
    logic [NO-1:0][CW-1:0] credit_count;
    logic                  credit_overflow;

    typedef struct {
        string                 name;
        logic [NI-1:0]         grant;
        logic [NO-1:0]         send;
        logic [NO-1:0][IW-1:0] xbar;
        logic [NO-1:0][CW-1:0] cred;
        logic                  ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    logic [NO-1:0][IW-1:0] exp_xbar;
    logic [NO-1:0][CW-1:0] exp_cred;
    logic                  exp_ovf;

    router_switch_allocator dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_port        (req_port),
        .req_is_tail     (req_is_tail),
        .disable_turns   (disable_turns),
        .credit_in       (credit_in),
        .grant           (grant),
        .xbar_sel        (xbar_sel),
        .out_send        (out_send),
        .credit_count    (credit_count),
        .credit_overflow (credit_overflow)
    );

    always #5 clk = ~clk;

    task automatic clearInputs();
        req_valid   = '0;
        req_port    = '0;
        req_is_tail = '0;
        credit_in   = '0;
    endtask

    task automatic setReq(input int i, input int port, input logic tail);
        req_valid[i]   = 1'b1;
        req_port[i]    = PW'(port);
        req_is_tail[i] = tail;
    endtask

    // Record the expected response for the inputs currently driven, then advance one cycle
    task automatic applyStimulus(input string name, input logic [NI-1:0] g, input logic [NO-1:0] s);
        exp_t e;
        e.name  = name;
        e.grant = g;
        e.send  = s;
        e.xbar  = exp_xbar;
        e.cred  = exp_cred;
        e.ovf   = exp_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string what, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", what, actual, required);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation every falling edge
    initial begin
        exp_t e;
        int   idle;
        idle = 0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput({e.name, " grant"},           32'(grant),           32'(e.grant));
                checkOutput({e.name, " out_send"},        32'(out_send),        32'(e.send));
                checkOutput({e.name, " xbar_sel"},        32'(xbar_sel),        32'(e.xbar));
                checkOutput({e.name, " credit_count"},    32'(credit_count),    32'(e.cred));
                checkOutput({e.name, " credit_overflow"}, 32'(credit_overflow), 32'(e.ovf));
            end else if (stim_done) begin
                break;
            end else begin
                idle++;
                if (idle > 2000) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL watchdog actual=no_stimulus required=stimulus_done");
                    break;
                end
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Directed stimulus sequence
    initial begin
        disable_turns = '0;
        disable_turns[NORTH][SOUTH] = 1'b1;
        clearInputs();
        exp_xbar = '0;
        exp_cred = {NO{2'd2}};
        exp_ovf  = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus("reset_hold", 5'b00000, 5'b00000);

        rst_n = 1'b1;
        applyStimulus("idle", 5'b00000, 5'b00000);

        $display("[TB] round-robin on LOCAL output");
        setReq(NORTH, LOCAL, 1'b1);
        setReq(EAST, LOCAL, 1'b1);
        credit_in[LOCAL] = 1'b1;
        exp_xbar[LOCAL] = 3'd1;
        applyStimulus("rr_a0", 5'b00010, 5'b00001);
        exp_xbar[LOCAL] = 3'd3;
        applyStimulus("rr_a1", 5'b01000, 5'b00001);
        exp_xbar[LOCAL] = 3'd1;
        applyStimulus("rr_a2", 5'b00010, 5'b00001);
        exp_xbar[LOCAL] = 3'd3;
        applyStimulus("rr_a3", 5'b01000, 5'b00001);
        clearInputs();
        applyStimulus("rr_hold", 5'b00000, 5'b00000);

        $display("[TB] wormhole lock on WEST output");
        setReq(SOUTH, WEST, 1'b0);
        credit_in[WEST] = 1'b1;
        exp_xbar[WEST] = 3'd2;
        applyStimulus("wh_head", 5'b00100, 5'b10000);
        setReq(LOCAL, WEST, 1'b1);
        applyStimulus("wh_body_blocks0", 5'b00100, 5'b10000);
        req_valid[SOUTH] = 1'b0;
        credit_in[WEST]  = 1'b0;
        applyStimulus("wh_bubble", 5'b00000, 5'b00000);
        setReq(SOUTH, WEST, 1'b1);
        credit_in[WEST] = 1'b1;
        applyStimulus("wh_tail", 5'b00100, 5'b10000);
        req_valid[SOUTH] = 1'b0;
        exp_xbar[WEST] = 3'd0;
        applyStimulus("wh_after_tail", 5'b00001, 5'b10000);

        $display("[TB] credit exhaustion on EAST output");
        clearInputs();
        setReq(WEST, EAST, 1'b1);
        exp_xbar[EAST] = 3'd4;
        applyStimulus("cr_send1", 5'b10000, 5'b01000);
        exp_cred[EAST] = 2'd1;
        applyStimulus("cr_send2", 5'b10000, 5'b01000);
        exp_cred[EAST] = 2'd0;
        applyStimulus("cr_stall", 5'b00000, 5'b00000);
        credit_in[EAST] = 1'b1;
        applyStimulus("cr_return", 5'b00000, 5'b00000);
        credit_in[EAST] = 1'b0;
        exp_cred[EAST] = 2'd1;
        applyStimulus("cr_regrant", 5'b10000, 5'b01000);
        clearInputs();
        credit_in[EAST] = 1'b1;
        exp_cred[EAST] = 2'd0;
        applyStimulus("cr_refill0", 5'b00000, 5'b00000);
        exp_cred[EAST] = 2'd1;
        applyStimulus("cr_refill1", 5'b00000, 5'b00000);
        clearInputs();
        exp_cred[EAST] = 2'd2;

        $display("[TB] disabled turn NORTH to SOUTH");
        setReq(NORTH, SOUTH, 1'b1);
        applyStimulus("turn_blocked", 5'b00000, 5'b00000);
        setReq(LOCAL, SOUTH, 1'b1);
        credit_in[SOUTH] = 1'b1;
        applyStimulus("turn_other", 5'b00001, 5'b00100);
        clearInputs();
        setReq(NORTH, SOUTH, 1'b1);
        applyStimulus("turn_blocked2", 5'b00000, 5'b00000);

        $display("[TB] credit overflow and mid-packet reset");
        clearInputs();
        credit_in[LOCAL] = 1'b1;
        applyStimulus("ovf_set", 5'b00000, 5'b00000);
        credit_in[LOCAL] = 1'b0;
        exp_ovf = 1'b1;
        applyStimulus("ovf_sticky", 5'b00000, 5'b00000);
        setReq(SOUTH, WEST, 1'b0);
        credit_in[WEST] = 1'b1;
        exp_xbar[WEST] = 3'd2;
        applyStimulus("rst_pre_lock", 5'b00100, 5'b10000);
        rst_n = 1'b0;
        setReq(LOCAL, WEST, 1'b1);
        credit_in[WEST] = 1'b0;
        exp_xbar = '0;
        exp_cred = {NO{2'd2}};
        exp_ovf  = 1'b0;
        applyStimulus("rst_mid_packet", 5'b00000, 5'b00000);
        rst_n = 1'b1;
        applyStimulus("rst_lock_dropped", 5'b00001, 5'b10000);
        clearInputs();
        exp_cred[WEST] = 2'd1;
        applyStimulus("rst_credit_after", 5'b00000, 5'b00000);

        stim_done = 1'b1;
    end

endmodule

// File: doc/router_switch_allocator.md
Name: router_switch_allocator

Overview:
- Per-cycle switch allocator for the mesh router crossbar, NUM_INPUTS x NUM_OUTPUTS (input 0 = local injection, 1..4 = N/S/E/W).
- Sits between the per-input flit buffers/route-compute stage and the crossbar.
- Wormhole policy: an output is locked to one input from head flit to tail flit.
- Unlocked outputs are shared round-robin. Downstream credits are tracked per output, so no flit is sent without buffer space.

Parameters:
NUM_INPUTS, 5, number of router input ports
NUM_OUTPUTS, 5, number of router output ports
FLIT_BUFFER_DEPTH, 2, downstream buffer depth per output (initial credits)
IN_WIDTH, $clog2(NUM_INPUTS), crossbar select width
PORT_WIDTH, $clog2(NUM_OUTPUTS), routed output-port index width
CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width

Ports:
clk  in  1  router clock (clk_noc domain)
rst_n  in  1  asynchronous active-low reset
req_valid  in  [NUM_INPUTS]  input i has a flit at buffer head
req_port  in  [NUM_INPUTS][PORT_WIDTH]  computed output port for that flit
req_is_tail  in  [NUM_INPUTS]  head-of-buffer flit is a tail
disable_turns  in  [NUM_INPUTS][NUM_OUTPUTS]  1 = turn i->o forbidden
credit_in  in  [NUM_OUTPUTS]  one credit returned by downstream this cycle
grant  out  [NUM_INPUTS]  input i dequeues its flit this cycle
xbar_sel  out  [NUM_OUTPUTS][IN_WIDTH]  crossbar select per output
out_send  out  [NUM_OUTPUTS]  flit driven on output o this cycle
credit_count  out  [NUM_OUTPUTS][CREDIT_WIDTH]  current credits per output
credit_overflow  out  1  sticky error flag

Behaviour:
- Eligibility: req_valid[i] && req_port[i]==o && !disable_turns[i][o]. Out-of-range req_port matches no output and is never granted.
- Per-output state: lock_valid, lock_owner, rr_ptr, credit_count.
- Allocation is combinational from inputs plus registered state. Zero-cycle latency: grant, xbar_sel and out_send are valid in the same cycle as the request.
- Locked output: only lock_owner may win. It is granted iff eligible and credit_count>0.
- Unlocked output: winner = first eligible input scanning rr_ptr, rr_ptr+1, … mod NUM_INPUTS. Granted iff credit_count>0.
- No credit: no grant; all state holds.
- Per-output state machine: IDLE (unlocked) / LOCKED(owner).
  - IDLE + grant of non-tail flit -> LOCKED(winner).
  - IDLE + grant of tail (single-flit packet) -> stays IDLE; rr_ptr <= winner+1 mod NUM_INPUTS.
  - LOCKED + grant of tail -> IDLE; rr_ptr <= owner+1 mod NUM_INPUTS.
  - LOCKED with owner not requesting (bubble): stays LOCKED, output idle, other inputs blocked.
- rr_ptr changes only at packet end.
- grant[i] = OR over o of (output o granted to i). At most one output can grant a given input, since each input routes to one port.
- xbar_sel[o] = granted input when out_send[o], else the last value (held register, reset 0).
- Credits: next = count − out_send[o] + credit_in[o]. Send and return in the same cycle leave the count unchanged.
- credit_in arriving with count==FLIT_BUFFER_DEPTH and no send: saturate at FLIT_BUFFER_DEPTH, set credit_overflow. It clears only on reset.
- disable_turns is static configuration: it may change only while rst_n is low. A change while LOCKED has undefined behaviour.
- Reset values (asynchronous, immediate): grant=0, out_send=0, xbar_sel=0, all outputs IDLE, rr_ptr=0, credit_count=FLIT_BUFFER_DEPTH, credit_overflow=0.
- Outputs are gated to 0 while rst_n=0.
- Reset mid-packet drops all locks; upstream flushes its buffers under the same reset.

Decomposition:
- router_pkg: port index constants (LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4).
- router_pkg: typedef alloc_state_e {ALLOC_IDLE, ALLOC_LOCKED}.
- Sub-module rr_arbiter (NUM_REQ param): request vector + pointer -> one-hot grant + encoded index, purely combinational.
  - One instance per output; lock/credit/pointer logic stays in the top module.

Test Plan:
- Reset release, no requests -> grant=0, credit_count=2 on all outputs, credit_overflow=0.
- Inputs 1 and 3 both request output 0 with single-flit packets, credits replenished every cycle -> grants alternate 1,3,1,3; xbar_sel[0] follows.
- Input 2 sends a 3-flit packet to output 4 while input 0 also requests port 4 -> input 0 is blocked until the cycle after input 2's tail, then granted. Insert a bubble mid-packet from input 2 -> output 4 idles, still locked.
- Output 3 with no credit_in for 3 cycles, continuous request -> 2 flits sent, credit_count=0, third flit stalled. credit_in=1 -> grant in the same cycle the count is 1.
- disable_turns[1][2]=1, input 1 requests port 2 -> never granted. Input 0 to port 2 is still granted.
- credit_in[0]=1 with count=2 and no send -> count stays 2, credit_overflow=1. Assert rst_n=0 mid-packet -> locks and flag cleared immediately.
